// File: rtl/status_snapshot_seq.sv
// Coherent status snapshot streamer: captures NUM_REGS words in one cycle and streams them out.
// Optional macro STATUS_SNAPSHOT_CKSUM_EN appends an XOR checksum word at index NUM_REGS.
module status_snapshot_seq #(
    parameter int NUM_REGS = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [32*NUM_REGS-1:0]  status_in,
    input  logic                    snap_req,
    input  logic [31:0]             period_cfg,
    output logic [31:0]             out_data,
    output logic [4:0]              out_index,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    busy,
    output logic [15:0]             snap_count,
    output logic [15:0]             drop_count
);

`ifdef STATUS_SNAPSHOT_CKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CKSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

    localparam logic [4:0] LAST_WORD = 5'(NUM_REGS - 1);

    state_t                     state, state_nxt;
    logic [NUM_REGS-1:0][31:0]  shadow;
    logic [4:0]                 idx;
    logic                       pending;
    logic [31:0]                tmr;
    logic                       tick, evt;
    logic                       capture, advance, done;

    // A shrunk period_cfg that leaves tmr past the new limit still ticks and reloads.
    always_comb begin
        tick = (period_cfg != 32'd0) && (tmr >= period_cfg - 32'd1);
        evt  = snap_req | tick;
    end

`ifdef STATUS_SNAPSHOT_CKSUM_EN
    logic [31:0] cksum;
    always_comb begin
        cksum = '0;
        for (int k = 0; k < NUM_REGS; k++) cksum = cksum ^ shadow[k];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        done      = 1'b0;
        out_data  = '0;
        out_index = '0;
        out_last  = 1'b0;
        out_valid = (state != IDLE);
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (evt || pending) begin
                    capture   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                out_data  = shadow[idx];
                out_index = idx;
`ifndef STATUS_SNAPSHOT_CKSUM_EN
                out_last  = (idx == LAST_WORD);
`endif
                if (out_ready) begin
                    if (idx == LAST_WORD) begin
`ifdef STATUS_SNAPSHOT_CKSUM_EN
                        state_nxt = CKSUM;
`else
                        state_nxt = IDLE;
                        done      = 1'b1;
`endif
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
`ifdef STATUS_SNAPSHOT_CKSUM_EN
            CKSUM: begin
                out_data  = cksum;
                out_index = 5'(NUM_REGS);
                out_last  = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow bank is only ever loaded at capture, so a snapshot is coherent to one cycle.
    always_ff @(posedge clk) begin
        if (capture) shadow <= status_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            pending    <= 1'b0;
            tmr        <= '0;
            snap_count <= '0;
            drop_count <= '0;
        end else begin
            if (period_cfg == 32'd0 || tick) tmr <= '0;
            else                             tmr <= tmr + 32'd1;

            if (capture)      idx <= '0;
            else if (advance) idx <= idx + 5'd1;

            // In IDLE an event is consumed by the capture itself.
            if (capture) begin
                pending <= 1'b0;
            end else if (evt && state != IDLE) begin
                if (!pending)                    pending    <= 1'b1;
                else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end

            if (done) snap_count <= snap_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_status_snapshot_seq.sv
// Directed self-checking bench for status_snapshot_seq; expectations follow the macro build.
module tb_status_snapshot_seq;
    localparam int NR = 26;
`ifdef STATUS_SNAPSHOT_CKSUM_EN
    localparam int LAST = NR;
`else
    localparam int LAST = NR - 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [32*NR-1:0]  status_in;
    logic              snap_req;
    logic [31:0]       period_cfg;
    logic [31:0]       out_data;
    logic [4:0]        out_index;
    logic              out_valid, out_last, out_ready, busy;
    logic [15:0]       snap_count, drop_count;

    int tests = 0;
    int fails = 0;

    status_snapshot_seq #(.NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .status_in(status_in), .snap_req(snap_req),
        .period_cfg(period_cfg), .out_data(out_data), .out_index(out_index),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .snap_count(snap_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] base, input int i);
        logic [31:0] x;
        x = '0;
        if (i < NR) return base + 32'(i);
        for (int k = 0; k < NR; k++) x = x ^ (base + 32'(k));
        return x;
    endfunction

    task automatic set_words(input logic [31:0] base);
        for (int k = 0; k < NR; k++) status_in[32*k +: 32] = base + 32'(k);
    endtask

    task automatic pulse_req();
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; snap_req = 1'b0; period_cfg = '0; out_ready = 1'b0; status_in = '0;
        repeat (3) @(negedge clk);
        tests++;
        if ({out_valid, busy, out_last, out_data, out_index, snap_count, drop_count} !== '0) begin
            fails++;
            $display("FAIL reset_state: valid=%b busy=%b last=%b data=%h idx=%0d snap=%0d drop=%0d, want all 0",
                     out_valid, busy, out_last, out_data, out_index, snap_count, drop_count);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_idle: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic();
        logic [38:0] got, exp;
        set_words(32'h1000_0000);
        out_ready = 1'b1;
        pulse_req();
        for (int k = 0; k <= LAST; k++) begin
            got = {out_valid, out_index, out_data, out_last};
            exp = {1'b1, 5'(k), exp_word(32'h1000_0000, k), (k == LAST)};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL basic_word%0d: got v=%b i=%0d d=%h l=%b, want v=1 i=%0d d=%h l=%b",
                         k, got[38], got[37:33], got[32:1], got[0], k, exp[32:1], exp[0]);
            end
            @(negedge clk);
        end
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || snap_count !== 16'd1) begin
            fails++;
            $display("FAIL basic_end: valid=%b data=%h snap=%0d, want 0 0 1", out_valid, out_data, snap_count);
        end
    endtask

    task automatic test_coherent();
        int  exp_idx, cyc;
        logic fin;
        set_words(32'h2000_0000);
        out_ready = 1'b0;
        pulse_req();
        exp_idx = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 200) begin
            tests++;
            if ({out_valid, out_index, out_data, out_last} !==
                {1'b1, 5'(exp_idx), exp_word(32'h2000_0000, exp_idx), (exp_idx == LAST)}) begin
                fails++;
                $display("FAIL coherent_cyc%0d: v=%b i=%0d d=%h l=%b, want i=%0d d=%h",
                         cyc, out_valid, out_index, out_data, out_last, exp_idx,
                         exp_word(32'h2000_0000, exp_idx));
            end
            set_words(32'hDEAD_0000 + 32'(cyc) * 32'h100);
            out_ready = ~out_ready;
            if (out_ready) begin
                if (exp_idx == LAST) fin = 1'b1;
                else                 exp_idx++;
            end
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (!fin || out_valid !== 1'b0 || snap_count !== 16'd2) begin
            fails++;
            $display("FAIL coherent_end: done=%b valid=%b snap=%0d, want 1 0 2", fin, out_valid, snap_count);
        end
    endtask

    task automatic test_periodic();
        int   nstart, cyc, n;
        logic prev;
        set_words(32'h3000_0000);
        out_ready = 1'b1;
        period_cfg = 32'd100;
        nstart = 0; cyc = 0; prev = 1'b0;
        while (nstart < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !prev) begin
                tests++;
                if (cyc != 100 * (nstart + 1) || out_index !== 5'd0) begin
                    fails++;
                    $display("FAIL periodic_start%0d: cycle=%0d idx=%0d, want cycle=%0d idx=0",
                             nstart, cyc, out_index, 100 * (nstart + 1));
                end
                nstart++;
                if (nstart == 3) period_cfg = '0;
            end
            prev = out_valid;
        end
        n = 0;
        while (out_valid && n < 60) begin @(negedge clk); n++; end
        tests++;
        if (nstart != 3 || out_valid !== 1'b0 || snap_count !== 16'd5 || drop_count !== 16'd0) begin
            fails++;
            $display("FAIL periodic_end: starts=%0d valid=%b snap=%0d drop=%0d, want 3 0 5 0",
                     nstart, out_valid, snap_count, drop_count);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        set_words(32'h4000_0000);
        out_ready = 1'b0;
        pulse_req();
        repeat (3) begin
            pulse_req();
            @(negedge clk);
        end
        tests++;
        if (drop_count !== 16'd2 || out_valid !== 1'b1 || out_index !== 5'd0) begin
            fails++;
            $display("FAIL b2b_drop: drop=%0d valid=%b idx=%0d, want 2 1 0", drop_count, out_valid, out_index);
        end
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_last) && n < 60) begin @(negedge clk); n++; end
        tests++;
        if (!(out_valid && out_last)) begin
            fails++;
            $display("FAIL b2b_last_timeout: valid=%b last=%b, want 1 1", out_valid, out_last);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle_gap: valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_index !== 5'd0 || out_data !== 32'h4000_0000) begin
            fails++;
            $display("FAIL b2b_pending_start: valid=%b idx=%0d data=%h, want 1 0 40000000",
                     out_valid, out_index, out_data);
        end
        n = 0;
        while (out_valid && n < 60) begin @(negedge clk); n++; end
        n = 0;
        repeat (5) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        tests++;
        if (n != 0 || snap_count !== 16'd7 || drop_count !== 16'd2) begin
            fails++;
            $display("FAIL b2b_end: extra_valid_cycles=%0d snap=%0d drop=%0d, want 0 7 2", n, snap_count, drop_count);
        end
    endtask

    task automatic test_cksum();
        int n;
        logic [31:0] want;
        out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) status_in = '1;
            else begin
                status_in = '0;
                status_in[0] = 1'b1;
            end
`ifdef STATUS_SNAPSHOT_CKSUM_EN
            want = (pass == 0) ? 32'h0000_0000 : 32'h0000_0001;
`else
            want = (pass == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
`endif
            pulse_req();
            n = 0;
            while (!(out_valid && out_last) && n < 60) begin @(negedge clk); n++; end
            tests++;
            if (out_valid !== 1'b1 || out_last !== 1'b1 || out_index !== 5'(LAST) || out_data !== want) begin
                fails++;
                $display("FAIL cksum_pass%0d: v=%b l=%b i=%0d d=%h, want 1 1 %0d %h",
                         pass, out_valid, out_last, out_index, out_data, LAST, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        set_words(32'h5000_0000);
        out_ready = 1'b1;
        pulse_req();
        n = 0;
        while (out_index != 5'd10 && n < 40) begin @(negedge clk); n++; end
        tests++;
        if (out_index !== 5'd10 || out_data !== 32'h5000_000A) begin
            fails++;
            $display("FAIL abort_reach10: idx=%0d data=%h, want 10 5000000a", out_index, out_data);
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({out_valid, busy, out_last, snap_count, drop_count} !== '0) begin
            fails++;
            $display("FAIL abort_state: valid=%b busy=%b last=%b snap=%0d drop=%0d, want all 0",
                     out_valid, busy, out_last, snap_count, drop_count);
        end
        reset = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid || snap_count != 16'd0) n++;
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL abort_no_resume: bad_cycles=%0d, want 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coherent();
        test_periodic();
        test_back_to_back();
        test_cksum();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
